// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset vector and word type
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {instr, pc} holding buffer for fetch responses
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::XLEN
) (
  input  logic         clk,
  input  logic         load,
  input  logic         drain,
  input  logic         flush,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc_in,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc
);

  // A simultaneous drain and load replaces the drained entry with the new one.
  always_ff @(posedge clk) begin
    if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && load) begin
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction-fetch stage with skid buffering and redirect
module fetch_unit #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            Pcsrc,
  input  logic [XLEN-1:0] ImmOp,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid
);
  import cpu_pkg::*;

  logic [XLEN-1:0] pc_fetch;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;

  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic            consume;
  logic            redirect;
  logic            out_free;
  logic            land;
  logic            skid_load;
  logic            skid_drain;
  logic [1:0]      occ;
  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] target;

  assign consume  = instr_valid & ~stall;
  assign redirect = consume & Pcsrc;
  assign out_free = ~instr_valid | consume;
  assign land     = inflight & ~redirect;

  // Never more than two entries are owed to decode, so occ fits in 2 bits.
  assign occ = {1'b0, instr_valid} + {1'b0, skid_valid} + {1'b0, inflight};

  assign imem_en   = ~rst & ~redirect & ((occ - {1'b0, consume}) < 2'd2);
  assign imem_addr = pc_fetch;

  assign target_sum = instr_pc + ImmOp;
  assign target     = {target_sum[XLEN-1:2], 2'b00};

  // Response goes to skid when the skid still holds an older entry or output is blocked.
  assign skid_load  = land & (skid_valid | ~out_free);
  assign skid_drain = ~redirect & out_free & skid_valid;

  fetch_skid_buf #(
    .W(XLEN)
  ) u_skid (
    .clk      (clk),
    .load     (skid_load),
    .drain    (skid_drain),
    .flush    (rst | redirect),
    .instr_in (imem_rdata),
    .pc_in    (inflight_pc),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_fetch    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc_fetch <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        pc_fetch    <= pc_fetch + XLEN'(INSTR_BYTES);
        inflight_pc <= pc_fetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        instr       <= skid_instr;
        instr_pc    <= skid_pc;
        instr_valid <= 1'b1;
      end else if (inflight) begin
        instr       <= imem_rdata;
        instr_pc    <= inflight_pc;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pcsrc;
  logic [31:0] immop;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  logic        imem_en2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2 = 32'h0;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic        instr_valid2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .Pcsrc      (pcsrc),
    .ImmOp      (immop),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .stall      (1'b0),
    .Pcsrc      (1'b0),
    .ImmOp      (32'h0),
    .imem_en    (imem_en2),
    .imem_addr  (imem_addr2),
    .imem_rdata (imem_rdata2),
    .instr      (instr2),
    .instr_pc   (instr_pc2),
    .instr_valid(instr_valid2)
  );

  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= imem_addr  ^ 32'hA5A5_0000;
    if (imem_en2) imem_rdata2 <= imem_addr2 ^ 32'hA5A5_0000;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check_eq({tag, "_pc"}, instr_pc, pc);
    check_eq({tag, "_instr"}, instr, pc ^ 32'hA5A5_0000);
  endtask

  task automatic expect_wrap(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'b0, instr_valid2}, 32'd1);
    check_eq({tag, "_pc"}, instr_pc2, pc);
    check_eq({tag, "_instr"}, instr2, pc ^ 32'hA5A5_0000);
  endtask

  task automatic expect_bubble(input string tag);
    check_eq({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; immop = 32'h0;
    step(); step();
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_pc", instr_pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_en", {31'b0, imem_en}, 32'd0);
    check_eq("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);

    // Basic streaming and first-valid latency.
    rst = 1'b0; #1;
    check_eq("t1_first_en", {31'b0, imem_en}, 32'd1);
    step();
    expect_bubble("t1_lat1");
    check_eq("t1_addr1", imem_addr, 32'h4);
    step(); expect_out("t1_0", 32'h0); expect_wrap("t6_0", 32'hFFFF_FFF8);
    step(); expect_out("t1_4", 32'h4); expect_wrap("t6_1", 32'hFFFF_FFFC);
    step(); expect_out("t1_8", 32'h8); expect_wrap("t6_2", 32'h0000_0000);

    // Stall while occupancy is full; hold then resume without gap.
    stall = 1'b1; #1;
    check_eq("t2_en_drop", {31'b0, imem_en}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("t2_hold", 32'h8);
      check_eq("t2_en_hold", {31'b0, imem_en}, 32'd0);
      check_eq("t2_addr_hold", imem_addr, 32'h10);
    end
    stall = 1'b0;
    step(); expect_out("t2_c", 32'hC);
    step(); expect_out("t2_10", 32'h10);
    step(); expect_out("t2_14", 32'h14);

    // Taken redirect at 0x8 with +0x10.
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step(); step();
    expect_out("t3_8", 32'h8);
    pcsrc = 1'b1; immop = 32'h10; #1;
    check_eq("t3_en_redir", {31'b0, imem_en}, 32'd0);
    step(); pcsrc = 1'b0;
    expect_bubble("t3_b1");
    check_eq("t3_target", imem_addr, 32'h18);
    step(); expect_bubble("t3_b2");
    step(); expect_out("t3_18", 32'h18);
    step(); expect_out("t3_1c", 32'h1C);
    step(); expect_out("t3_20", 32'h20);

    // Pcsrc ignored under stall, then negative offset, then unaligned offset.
    stall = 1'b1; pcsrc = 1'b1; immop = 32'h100;
    step(); expect_out("t4_ign", 32'h20);
    stall = 1'b0; immop = 32'hFFFF_FFF8;
    step(); pcsrc = 1'b0;
    expect_bubble("t4_neg_b1");
    check_eq("t4_neg_target", imem_addr, 32'h18);
    step(); expect_bubble("t4_neg_b2");
    step(); expect_out("t4_18", 32'h18);
    step(); expect_out("t4_1c", 32'h1C);
    step(); expect_out("t4_20", 32'h20);
    pcsrc = 1'b1; immop = 32'h6;
    step(); pcsrc = 1'b0;
    expect_bubble("t4_lsb_b1");
    check_eq("t4_lsb_target", imem_addr, 32'h24);
    step(); expect_bubble("t4_lsb_b2");
    step(); expect_out("t4_24", 32'h24);

    // Reset while stalled with output and skid occupied.
    stall = 1'b1;
    step(); expect_out("t5_full", 32'h24);
    check_eq("t5_en_full", {31'b0, imem_en}, 32'd0);
    rst = 1'b1;
    step();
    expect_bubble("t5_rst");
    check_eq("t5_addr", imem_addr, 32'h0);
    check_eq("t5_en", {31'b0, imem_en}, 32'd0);
    rst = 1'b0; stall = 1'b0;
    step(); expect_bubble("t5_lat");
    step(); expect_out("t5_0", 32'h0);
    step(); expect_out("t5_4", 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
